// File: rtl/ext_pkg.sv
// ext_pkg: mode encodings and buffer depth shared by the extension unit files
package ext_pkg;
  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_UPPER  = 2'b10;
  localparam logic [1:0] EXT_BRANCH = 2'b11;
  localparam int EXT_DEPTH = 2;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational zero/sign/upper/branch immediate extension
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext_data
);
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("ext_core: OUT_W must be at least IN_W+2");
  end
  logic [OUT_W-1:0] zx, sx;
  assign zx = {{(OUT_W-IN_W){1'b0}}, in_data};
  assign sx = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  // branch offsets are word-scaled, so the sign-extended value drops its top two bits
  always_comb
    ext_data = in_mode == EXT_ZERO  ? zx :
               in_mode == EXT_SIGN  ? sx :
               in_mode == EXT_UPPER ? {in_data, {(OUT_W-IN_W){1'b0}}} :
                                      sx << 2;
endmodule

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: handshaked immediate extender with 2-entry result FIFO; EXT_UNIT_STATS_EN adds stat_count
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef EXT_UNIT_STATS_EN
  ,
  output logic [31:0]      stat_count
`endif
);
  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] mem [EXT_DEPTH];
  logic             head, tail;
  logic [1:0]       count;
  logic             acc, con;
  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .in_data (in_data),
    .in_mode (in_mode),
    .ext_data(ext_data)
  );
  assign in_ready  = (count != 2'(EXT_DEPTH)) && !rst;
  assign out_valid = count != 2'd0;
  assign out_data  = mem[head];
  assign acc = in_valid && in_ready;
  assign con = out_valid && out_ready;
  // result is latched at accept time; reset clears entries so out_data reads zero
  always_ff @(posedge clk)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (acc) begin
        mem[tail] <= ext_data;
        tail      <= ~tail;
      end
      if (con) head <= ~head;
      count <= count + 2'(acc) - 2'(con);
    end
`ifdef EXT_UNIT_STATS_EN
  // consume counter, wraps naturally at 2^32
  always_ff @(posedge clk)
    stat_count <= rst ? 32'd0 : stat_count + 32'(con);
`endif
endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb_ext_unit_pipe: scoreboard bench for ext_unit_pipe (stats checks when EXT_UNIT_STATS_EN is defined)
module tb_ext_unit_pipe;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_data;
`ifdef EXT_UNIT_STATS_EN
  logic [31:0] stat_count;
`endif
  int pass_cnt = 0;
  int total = 0;
  int cons = 0;
  logic [31:0] q [$];

  ext_unit_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef EXT_UNIT_STATS_EN
    , .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
    logic signed [31:0] s;
    s = 32'($signed(d));
    case (m)
      2'b00: return {16'h0000, d};
      2'b01: return s;
      2'b10: return 32'(d) * 32'd65536;
      default: return s * 4;
    endcase
  endfunction

  // scoreboard: push on accept, compare head every valid cycle, pop on consume
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid) begin
        total++;
        if (q.size() == 0) $display("FAIL sb_stale out_data=%h expected no valid output", out_data);
        else if (out_data !== q[0]) $display("FAIL sb_data out_data=%h expected %h", out_data, q[0]);
        else pass_cnt++;
        if (out_ready) begin
          cons++;
          if (q.size() != 0) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_data, in_mode));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", out_valid); else pass_cnt++;
    total++;
    if (out_data !== 32'h0) $display("FAIL reset_out_data got %h expected 0", out_data); else pass_cnt++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_modes();
    logic [15:0] td [6] = '{16'hfc57, 16'hfc57, 16'hfc57, 16'hfc57, 16'h7fff, 16'h8000};
    logic [1:0]  tm [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01};
    logic [31:0] te [6] = '{32'h0000fc57, 32'hfffffc57, 32'hfc570000, 32'hfffff15c, 32'h0001fffc, 32'hffff8000};
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_data  = td[i];
      in_mode  = tm[i];
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) $display("FAIL mode%0d_in_ready got %b expected 1", i, in_ready); else pass_cnt++;
      tick();
      in_valid = 0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== te[i])
        $display("FAIL mode%0d_result got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, te[i]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stall();
    int c0;
    int guard;
    c0 = cons;
    out_ready = 0;
    in_valid = 1;
    in_mode = 2'b01;
    in_data = 16'h1234;
    tick();
    in_data = 16'h8abc;
    tick();
    in_data = 16'h0f0f;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b expected 0", in_ready); else pass_cnt++;
      total++;
      if (out_data !== 32'h00001234) $display("FAIL stall_hold got %h expected 00001234", out_data); else pass_cnt++;
      tick();
    end
    out_ready = 1;
    guard = 0;
    while (in_valid && guard < 10) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 0;
      end else tick();
      guard++;
    end
    total++;
    if (in_valid !== 1'b0) $display("FAIL stall_c_accept got in_valid still pending expected accepted");
    else pass_cnt++;
    in_valid = 0;
    repeat (4) tick();
    total++;
    if (cons - c0 !== 3) $display("FAIL stall_count got %0d results expected 3", cons - c0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cons;
    out_ready = 1;
    in_mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      in_data = 16'(i * 16'h1111 + 1);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) $display("FAIL b2b_in_ready%0d got %b expected 1", i, in_ready); else pass_cnt++;
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1) $display("FAIL b2b_valid%0d got %b expected 1", i, out_valid); else pass_cnt++;
      end
      tick();
    end
    in_valid = 0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) $display("FAIL b2b_last got %b expected 1", out_valid); else pass_cnt++;
    tick();
    tick();
    total++;
    if (cons - c0 !== 8) $display("FAIL b2b_count got %0d results expected 8", cons - c0); else pass_cnt++;
  endtask

  task automatic test_reset_full();
    int c0;
    out_ready = 0;
    in_valid = 1;
    in_mode = 2'b00;
    in_data = 16'haaaa;
    tick();
    in_data = 16'h5555;
    tick();
    in_valid = 0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b expected 0", in_ready); else pass_cnt++;
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL rstfull_valid got %b expected 0", out_valid); else pass_cnt++;
    total++;
    if (out_data !== 32'h0) $display("FAIL rstfull_data got %h expected 0", out_data); else pass_cnt++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rstfull_in_ready got %b expected 1", in_ready); else pass_cnt++;
    c0 = cons;
    out_ready = 1;
    repeat (3) tick();
    total++;
    if (cons - c0 !== 0) $display("FAIL rstfull_stale got %0d results expected 0", cons - c0); else pass_cnt++;
  endtask

`ifdef EXT_UNIT_STATS_EN
  task automatic test_stats();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    total++;
    if (stat_count !== 32'd0) $display("FAIL stat_reset got %0d expected 0", stat_count); else pass_cnt++;
    tick();
    out_ready = 1;
    in_mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = 16'(i);
      tick();
    end
    in_valid = 0;
    tick();
    @(negedge clk);
    total++;
    if (stat_count !== 32'd5) $display("FAIL stat_five got %0d expected 5", stat_count); else pass_cnt++;
    tick();
    force dut.stat_count = 32'hffffffff;
    #1;
    release dut.stat_count;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    @(negedge clk);
    total++;
    if (stat_count !== 32'd0) $display("FAIL stat_wrap got %h expected 0", stat_count); else pass_cnt++;
    tick();
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    total++;
    if (stat_count !== 32'd0) $display("FAIL stat_clear got %0d expected 0", stat_count); else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_modes();
    test_stall();
    test_back_to_back();
    test_reset_full();
`ifdef EXT_UNIT_STATS_EN
    test_stats();
`endif
    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
